// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the data-RAM arbiter.
package ram_arb_pkg;

    localparam int RAM_AW           = 12;
    localparam int RAM_DW           = 4;
    localparam int RAM_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle; slave = arbiter view, master = requesters/RAM view.
interface ram_arbiter_if #(
    parameter int AW = ram_arb_pkg::RAM_AW,
    parameter int DW = ram_arb_pkg::RAM_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_ack;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_ack, cpu_stall, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_ack, dbg_rdata,
        output ram_addr, ram_cs, ram_we, ram_oe, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_ack, cpu_stall, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_ack, dbg_rdata,
        input  ram_addr, ram_cs, ram_we, ram_oe, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/ram_arb_starve_cnt.sv
// Counts CPU grants taken while DBG waits; flags starvation at STARVE_LIMIT.
// Registered count, combinational compare; clears on DBG grant or when DBG drops its request.
module ram_arb_starve_cnt
    import ram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = RAM_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_dbg_req,
    input  logic i_cpu_grant,
    input  logic i_dbg_grant,
    output logic o_starved
);

    logic [3:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (!i_dbg_req || i_dbg_grant) begin
            r_cnt <= 4'd0;
        end else if (i_cpu_grant) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Qualified with the live request so a stale count can never steal a slot.
    assign o_starved = i_dbg_req && (r_cnt == 4'(STARVE_LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter, CPU priority; gnt one cycle after req, ack + rdata the cycle after.
// Losers stall with req held; RAM_ARB_STARVE_EN adds the bounded-wait DBG guard.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW           = RAM_AW,
    parameter int DW           = RAM_DW,
    parameter int STARVE_LIMIT = RAM_STARVE_LIMIT
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave bus
);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic          w_cpu_grant;
    logic          w_dbg_grant;
    logic          w_starved;

    logic          r_cpu_ack;
    logic          r_dbg_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dbg_rdata;

    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_ram_cs;
    logic          r_ram_we;
    logic          r_ram_oe;

`ifdef RAM_ARB_STARVE_EN
    ram_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clock       (clock),
        .reset       (reset),
        .i_dbg_req   (bus.dbg_req),
        .i_cpu_grant (w_cpu_grant),
        .i_dbg_grant (w_dbg_grant),
        .o_starved   (w_starved)
    );
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every access lasts one cycle, so only IDLE makes a decision.
    always_comb begin
        w_next      = IDLE;
        w_cpu_grant = 1'b0;
        w_dbg_grant = 1'b0;
        if (r_state == IDLE) begin
            if (bus.cpu_req && !w_starved) begin
                w_next      = CPU_ACC;
                w_cpu_grant = 1'b1;
            end else if (bus.dbg_req) begin
                w_next      = DBG_ACC;
                w_dbg_grant = 1'b1;
            end
        end
    end

    // RAM strobes are loaded on the grant edge so they come straight from flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_ram_cs    <= w_cpu_grant | w_dbg_grant;
            r_ram_we    <= (w_cpu_grant & bus.cpu_we) | (w_dbg_grant & bus.dbg_we);
            r_ram_oe    <= (w_cpu_grant & bus.cpu_we) | (w_dbg_grant & bus.dbg_we);
            r_ram_addr  <= w_cpu_grant ? bus.cpu_addr :
                           w_dbg_grant ? bus.dbg_addr : '0;
            r_ram_wdata <= (w_cpu_grant && bus.cpu_we) ? bus.cpu_wdata :
                           (w_dbg_grant && bus.dbg_we) ? bus.dbg_wdata : '0;
            r_cpu_ack   <= (r_state == CPU_ACC);
            r_dbg_ack   <= (r_state == DBG_ACC);
            if (r_state == CPU_ACC && !r_ram_we) begin
                r_cpu_rdata <= bus.ram_rdata;
            end
            if (r_state == DBG_ACC && !r_ram_we) begin
                r_dbg_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.cpu_gnt   = (r_state == CPU_ACC);
    assign bus.dbg_gnt   = (r_state == DBG_ACC);
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_gnt & ~r_cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_cs    = r_ram_cs;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_oe    = r_ram_oe;
    assign bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural async RAM and per-requester read scoreboards.
module tb_ram_arbiter;

    typedef struct packed {
        logic       rd;
        logic [3:0] dat;
    } exp_t;

    logic clock;
    logic reset;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] mem [4096];
    exp_t       cpu_q [$];
    exp_t       dbg_q [$];
    int         n_pass;
    int         n_total;
    int         n_cpu_ack;
    int         n_dbg_ack;
    int         acks_before;
    int         g;
    int         n_dbg_g;
    int         n_stall;
    logic       exp_dbg;
    exp_t       e_cpu;
    exp_t       e_dbg;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.ram_rdata = mem[bus.ram_addr];

    always @(posedge clock) begin
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard side: every ack must match a queued expectation.
    always @(negedge clock) begin
        if (bus.cpu_ack === 1'b1) begin
            n_cpu_ack++;
            check("cpu_sb_pending", 32'(cpu_q.size() != 0), 1);
            if (cpu_q.size() != 0) begin
                e_cpu = cpu_q.pop_front();
                if (e_cpu.rd) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_cpu.dat));
            end
        end
        if (bus.dbg_ack === 1'b1) begin
            n_dbg_ack++;
            check("dbg_sb_pending", 32'(dbg_q.size() != 0), 1);
            if (dbg_q.size() != 0) begin
                e_dbg = dbg_q.pop_front();
                if (e_dbg.rd) check("dbg_rdata", 32'(bus.dbg_rdata), 32'(e_dbg.dat));
            end
        end
    end

    initial begin
        n_pass = 0; n_total = 0; n_cpu_ack = 0; n_dbg_ack = 0;
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 4'(i * 7);
        mem[12'h123] = 4'hA;
        mem[12'h010] = 4'h3;
        mem[12'h020] = 4'hC;

        repeat (2) @(negedge clock);
        check("rst_req_outs", {bus.cpu_gnt, bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata,
                               bus.dbg_gnt, bus.dbg_ack, bus.dbg_rdata}, '0);
        check("rst_ram_outs", {bus.ram_addr, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_wdata}, '0);
        reset = 1'b0;

        // CPU read of 0x123
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
        cpu_q.push_back('{rd: 1'b1, dat: 4'hA});
        #1 check("cpu_stall_wait", 32'(bus.cpu_stall), 1);
        @(negedge clock);
        check("cpu_rd_gnt", {bus.cpu_gnt, bus.dbg_gnt, bus.ram_cs, bus.ram_we, bus.ram_oe}, 5'b10100);
        check("cpu_rd_addr", 32'(bus.ram_addr), 32'h123);
        @(negedge clock);
        check("cpu_rd_ack", {bus.cpu_ack, bus.cpu_gnt, bus.ram_cs}, 3'b100);
        check("ram_addr_idle", 32'(bus.ram_addr), 0);
        bus.cpu_req = 1'b0;

        // DBG write 0x5 to 0xFFF
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 12'hFFF; bus.dbg_wdata = 4'h5;
        dbg_q.push_back('{rd: 1'b0, dat: 4'h0});
        @(negedge clock);
        check("dbg_wr_gnt", {bus.dbg_gnt, bus.cpu_gnt, bus.ram_cs, bus.ram_we, bus.ram_oe}, 5'b10111);
        check("dbg_wr_addr", 32'(bus.ram_addr), 32'hFFF);
        check("dbg_wr_wdata", 32'(bus.ram_wdata), 32'h5);
        @(negedge clock);
        check("dbg_wr_ack", {bus.dbg_ack, bus.dbg_gnt, bus.ram_cs, bus.ram_oe}, 4'b1000);
        check("dbg_rdata_after_wr", 32'(bus.dbg_rdata), 0);
        bus.dbg_we = 1'b0; bus.dbg_wdata = 4'h0;
        dbg_q.push_back('{rd: 1'b1, dat: 4'h5});
        @(negedge clock);
        check("dbg_rd_gnt", {bus.dbg_gnt, bus.ram_we, bus.ram_oe}, 3'b100);
        check("dbg_rd_wdata", 32'(bus.ram_wdata), 0);
        @(negedge clock);
        check("dbg_rd_ack", 32'(bus.dbg_ack), 1);
        check("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'hA);
        bus.dbg_req = 1'b0;

        // CPU back-to-back reads, DBG idle
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h010;
        #1 check("b2b_stall_first", 32'(bus.cpu_stall), 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k % 2 == 1) cpu_q.push_back('{rd: 1'b1, dat: 4'h3});
            check("b2b_gnt", 32'(bus.cpu_gnt), 32'(k % 2));
            check("b2b_ack", 32'(bus.cpu_ack), 32'(k % 2 == 0));
            check("b2b_stall", 32'(bus.cpu_stall), 0);
        end
        bus.cpu_req = 1'b0;
        @(negedge clock);
        check("b2b_release", {bus.cpu_gnt, bus.ram_cs}, 2'b00);

        // Contention: both requesters held high
        bus.cpu_addr = 12'h010; bus.dbg_addr = 12'h020; bus.dbg_we = 1'b0;
        bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
        g = 0; n_dbg_g = 0; n_stall = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k % 2 == 1) begin
`ifdef RAM_ARB_STARVE_EN
                exp_dbg = (g % 5 == 4);
`else
                exp_dbg = 1'b0;
`endif
                if (exp_dbg) dbg_q.push_back('{rd: 1'b1, dat: 4'hC});
                else         cpu_q.push_back('{rd: 1'b1, dat: 4'h3});
                check("arb_owner", {bus.cpu_gnt, bus.dbg_gnt}, exp_dbg ? 2'b01 : 2'b10);
                g++;
            end
            if (bus.dbg_gnt) n_dbg_g++;
            if (bus.cpu_stall) n_stall++;
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
`ifdef RAM_ARB_STARVE_EN
        check("arb_dbg_grants", n_dbg_g, 4);
        check("arb_cpu_stalls", n_stall, 8);
`else
        check("arb_dbg_grants", n_dbg_g, 0);
        check("arb_cpu_stalls", n_stall, 0);
`endif

        // Reset in the middle of a CPU access
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h123;
        @(negedge clock);
        check("rst_acc_gnt", {bus.cpu_gnt, bus.ram_cs}, 2'b11);
        acks_before = n_cpu_ack;
        #1 reset = 1'b1; bus.cpu_req = 1'b0;
        #1 check("rst_acc_ram", {bus.ram_addr, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_wdata}, '0);
        check("rst_acc_req_outs", {bus.cpu_gnt, bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata,
                                   bus.dbg_gnt, bus.dbg_ack, bus.dbg_rdata}, '0);
        @(negedge clock);
        check("rst_hold_cs", 32'(bus.ram_cs), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("rst_no_ack", {bus.cpu_ack, bus.cpu_gnt, bus.ram_cs}, 3'b000);
        end
        check("rst_ack_count", n_cpu_ack - acks_before, 0);

        check("sb_cpu_empty", cpu_q.size(), 0);
        check("sb_dbg_empty", dbg_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
